ntt_sched: RTL and testbench

NTT_SCHED -- requirements
Module: ntt_sched

---
 rtl/ntt_pkg.sv | 19 +
 rtl/ntt_sched_rdbuf.sv | 94 +++++++++
 rtl/ntt_sched.sv | 176 +++++++++++++++++
 tb/tb_ntt_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT scheduler: state encoding, transform size and
// default coefficient width.
package ntt_pkg;

    localparam int NTT_N    = 256;
    localparam int NTT_LOGN = 8;
    localparam int NTT_CW   = 12;

    localparam logic [NTT_LOGN-1:0] NTT_LAST = NTT_LOGN'(NTT_N - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_UNLOAD = 3'd4
    } ntt_state_e;

endpackage

// File: rtl/ntt_sched_rdbuf.sv
// Unload path of the NTT scheduler: issues RAM reads in address order and holds
// each word in a registered output stage until the consumer takes it.
module ntt_sched_rdbuf
    import ntt_pkg::*;
#(
    parameter int CW = NTT_CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_active,
    input  logic                i_out_ready,
    input  logic [CW-1:0]       i_ram_rdata,
    output logic [NTT_LOGN-1:0] o_ram_addr,
    output logic                o_out_valid,
    output logic [CW-1:0]       o_out_data,
    output logic                o_done
);

    logic [NTT_LOGN-1:0] addr_q, addr_d;
    logic                issued_all_q, issued_all_d;
    logic                pend_q, pend_d;
    logic                pend_last_q, pend_last_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [CW-1:0]       data_q, data_d;
    logic                accept_s;
    logic                issue_s;

    // Read issue and output-register update; a word being taken this cycle
    // counts as empty so the next read overlaps the hand-off.
    always_comb begin
        accept_s     = valid_q && i_out_ready;
        issue_s      = i_active && !issued_all_q && !pend_q && (!valid_q || accept_s);
        addr_d       = addr_q;
        issued_all_d = issued_all_q;
        pend_d       = 1'b0;
        pend_last_d  = 1'b0;
        valid_d      = valid_q;
        last_d       = last_q;
        data_d       = data_q;
        if (!i_active) begin
            addr_d       = {NTT_LOGN{1'b0}};
            issued_all_d = 1'b0;
            valid_d      = 1'b0;
            last_d       = 1'b0;
        end else begin
            if (issue_s) begin
                pend_d       = 1'b1;
                pend_last_d  = (addr_q == NTT_LAST);
                issued_all_d = (addr_q == NTT_LAST);
                addr_d       = addr_q + NTT_LOGN'(1);
            end else begin
                pend_d = 1'b0;
            end
            if (pend_q) begin
                valid_d = 1'b1;
                data_d  = i_ram_rdata;
                last_d  = pend_last_q;
            end else if (accept_s) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end
    end

    // Unload state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= {NTT_LOGN{1'b0}};
            issued_all_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            data_q       <= {CW{1'b0}};
        end else begin
            addr_q       <= addr_d;
            issued_all_q <= issued_all_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            data_q       <= data_d;
        end
    end

    assign o_ram_addr  = addr_q;
    assign o_out_valid = valid_q;
    assign o_out_data  = data_q;
    assign o_done      = accept_s && last_q;

endmodule

// File: rtl/ntt_sched.sv
// NTT job scheduler: load 256 coefficients, run the address generator, drain
// the butterfly pipeline, unload results. NTT_SCHED_PERF_EN adds o_run_cycles.
module ntt_sched
    import ntt_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CW           = NTT_CW
) (
    input  logic                clk,
    input  logic                rst,
`ifdef NTT_SCHED_PERF_EN
    output logic [15:0]         o_run_cycles,
`endif
    input  logic                i_job_valid,
    output logic                o_job_ready,
    input  logic                i_in_valid,
    input  logic [CW-1:0]       i_in_data,
    output logic                o_in_ready,
    output logic                o_out_valid,
    output logic [CW-1:0]       o_out_data,
    input  logic                i_out_ready,
    output logic                o_ag_start,
    input  logic                i_ag_done,
    output logic                o_ram_sel,
    output logic                o_ram_we,
    output logic [NTT_LOGN-1:0] o_ram_addr,
    output logic [CW-1:0]       o_ram_wdata,
    input  logic [CW-1:0]       i_ram_rdata,
    output logic                o_busy
);

    // A zero drain length still spends one cycle in DRAIN.
    localparam int             DC_EFF  = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int             DCW     = (DC_EFF > 1) ? $clog2(DC_EFF) : 1;
    localparam logic [DCW-1:0] DC_INIT = DCW'(DC_EFF - 1);

    ntt_state_e          state_q, state_d;
    logic [NTT_LOGN-1:0] load_cnt_q, load_cnt_d;
    logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
    logic                ag_start_q, ag_start_d;
    logic                ram_sel_q, ram_sel_d;
    logic                busy_q, busy_d;
    logic                load_wr_s;
    logic                unload_s;
    logic                rd_done_s;
    logic [NTT_LOGN-1:0] rd_addr_s;

    assign load_wr_s = (state_q == ST_LOAD) && i_in_valid;
    assign unload_s  = (state_q == ST_UNLOAD);

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_job_valid) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = {NTT_LOGN{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_wr_s) begin
                    load_cnt_d = load_cnt_q + NTT_LOGN'(1);
                    if (load_cnt_q == NTT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    load_cnt_d = load_cnt_q;
                end
            end
            ST_RUN: begin
                if (i_ag_done) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DC_INIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == {DCW{1'b0}}) begin
                    state_d = ST_UNLOAD;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            ST_UNLOAD: begin
                if (rd_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_UNLOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ag_start_d = (state_d == ST_RUN);
        ram_sel_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        busy_d     = (state_d != ST_IDLE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= {NTT_LOGN{1'b0}};
            drain_cnt_q <= {DCW{1'b0}};
            ag_start_q  <= 1'b0;
            ram_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            ag_start_q  <= ag_start_d;
            ram_sel_q   <= ram_sel_d;
            busy_q      <= busy_d;
        end
    end

    ntt_sched_rdbuf #(
        .CW (CW)
    ) u_rdbuf (
        .clk         (clk),
        .rst         (rst),
        .i_active    (unload_s),
        .i_out_ready (i_out_ready),
        .i_ram_rdata (i_ram_rdata),
        .o_ram_addr  (rd_addr_s),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .o_done      (rd_done_s)
    );

    assign o_job_ready = (state_q == ST_IDLE);
    assign o_in_ready  = (state_q == ST_LOAD);
    assign o_ram_we    = load_wr_s;
    assign o_ram_addr  = (state_q == ST_LOAD) ? load_cnt_q : rd_addr_s;
    assign o_ram_wdata = (state_q == ST_LOAD) ? i_in_data : {CW{1'b0}};
    assign o_ag_start  = ag_start_q;
    assign o_ram_sel   = ram_sel_q;
    assign o_busy      = busy_q;

`ifdef NTT_SCHED_PERF_EN
    logic [15:0] run_cycles_q, run_cycles_d;

    // Cycles spent in RUN plus DRAIN for the current job, saturating.
    always_comb begin
        if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
            run_cycles_d = 16'h0000;
        end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (run_cycles_q != 16'hFFFF)) begin
            run_cycles_d = run_cycles_q + 16'h0001;
        end else begin
            run_cycles_d = run_cycles_q;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles_q <= 16'h0000;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign o_run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_ntt_sched.sv
// Directed-plus-random bench for ntt_sched: a RAM model, a reference array of
// loaded words and a linear job sequence checked with immediate assertions.
module tb_ntt_sched;

    localparam int CW = 12;
    localparam int DC = 4;

    logic          clk;
    logic          rst;
    logic          i_job_valid;
    logic          o_job_ready;
    logic          i_in_valid;
    logic [CW-1:0] i_in_data;
    logic          o_in_ready;
    logic          o_out_valid;
    logic [CW-1:0] o_out_data;
    logic          i_out_ready;
    logic          o_ag_start;
    logic          i_ag_done;
    logic          o_ram_sel;
    logic          o_ram_we;
    logic [7:0]    o_ram_addr;
    logic [CW-1:0] o_ram_wdata;
    logic [CW-1:0] i_ram_rdata;
    logic          o_busy;
`ifdef NTT_SCHED_PERF_EN
    logic [15:0]   o_run_cycles;
`endif

    int tests;
    int fails;

    logic [CW-1:0] mem [256];
    logic [CW-1:0] ref_mem [256];
    bit            xor_mode;
    int            wr_count;
    int            we_sel_viol;

    ntt_sched #(
        .DRAIN_CYCLES (DC),
        .CW           (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef NTT_SCHED_PERF_EN
        .o_run_cycles (o_run_cycles),
`endif
        .i_job_valid  (i_job_valid),
        .o_job_ready  (o_job_ready),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .i_out_ready  (i_out_ready),
        .o_ag_start   (o_ag_start),
        .i_ag_done    (i_ag_done),
        .o_ram_sel    (o_ram_sel),
        .o_ram_we     (o_ram_we),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .i_ram_rdata  (i_ram_rdata),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency, plus write bookkeeping.
    always @(posedge clk) begin
        if (o_ram_we) begin
            mem[o_ram_addr] <= o_ram_wdata;
            wr_count        <= wr_count + 1;
        end
        if (o_ram_we && o_ram_sel) begin
            we_sel_viol <= we_sel_viol + 1;
        end
        if (xor_mode) begin
            i_ram_rdata <= CW'(o_ram_addr ^ 8'hA5);
        end else begin
            i_ram_rdata <= mem[o_ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run for run_len cycles with done in the last one, then walk the drain.
    task automatic run_and_drain(input int run_len);
        int bad_run;
        int bad_drain;
        bad_run   = 0;
        bad_drain = 0;
        for (int c = 1; c <= run_len; c++) begin
            i_ag_done = (c == run_len);
            #1;
            if (o_ag_start !== 1'b1 || o_ram_sel !== 1'b1 || o_busy !== 1'b1) bad_run++;
            tick();
        end
        i_ag_done = 1'b0;
        #1;
        check("ag_start_drop", {31'd0, o_ag_start}, 32'd0);
        for (int d = 0; d < DC; d++) begin
            if (o_ram_sel !== 1'b1 || o_ag_start !== 1'b0 || o_out_valid !== 1'b0 || o_busy !== 1'b1) bad_drain++;
            tick();
            #1;
        end
        check("run_phase", bad_run, 0);
        check("drain_phase", bad_drain, 0);
        check("unload_sel", {31'd0, o_ram_sel}, 32'd0);
        check("unload_busy", {31'd0, o_busy}, 32'd1);
    endtask

    // Take all 256 results and compare them with what should have come back.
    task automatic unload_job(input bit use_xor, input bit toggle_ready);
        int            idx;
        int            cyc;
        int            jr_bad;
        logic          pv;
        logic          pr;
        logic [CW-1:0] pd;
        logic [CW-1:0] exp_w;
        idx    = 0;
        cyc    = 0;
        jr_bad = 0;
        pv     = 1'b0;
        pr     = 1'b1;
        pd     = '0;
        while (idx < 256 && cyc < 4000) begin
            if (toggle_ready) begin
                i_out_ready = (cyc % 2 == 0);
            end else begin
                i_out_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (o_job_ready !== 1'b0) jr_bad++;
            if (pv && !pr) begin
                check("hold_valid", {31'd0, o_out_valid}, 32'd1);
                check("hold_data", 32'(o_out_data), 32'(pd));
            end
            if (o_out_valid === 1'b1) begin
                if (use_xor) begin
                    exp_w = CW'(idx ^ 32'hA5);
                end else begin
                    exp_w = ref_mem[idx];
                end
                check("unload_data", 32'(o_out_data), 32'(exp_w));
                if (i_out_ready) idx++;
            end
            pv = o_out_valid;
            pr = i_out_ready;
            pd = o_out_data;
            tick();
            cyc++;
        end
        i_out_ready = 1'b0;
        check("unload_count", idx, 256);
        check("job_ready_in_unload", jr_bad, 0);
    endtask

    initial begin
        int            bad;
        int            k;
        int            cyc;
        int            wc;
        logic [CW-1:0] d;

        tests       = 0;
        fails       = 0;
        wr_count    = 0;
        we_sel_viol = 0;
        xor_mode    = 1'b0;
        rst         = 1'b1;
        i_job_valid = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_out_ready = 1'b0;
        i_ag_done   = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_job_ready", {31'd0, o_job_ready}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_ram_sel", {31'd0, o_ram_sel}, 32'd0);
        check("rst_ag_start", {31'd0, o_ag_start}, 32'd0);
        check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        check("rst_ram_we", {31'd0, o_ram_we}, 32'd0);
        check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
        check("rst_ram_addr", 32'(o_ram_addr), 32'd0);

        // Job 1: load 0..255 back-to-back, spurious done mid-load
        tick();
        i_job_valid = 1'b1;
        #1;
        check("job1_ready", {31'd0, o_job_ready}, 32'd1);
        tick();
        i_job_valid = 1'b0;
        bad = 0;
        for (int w = 0; w < 256; w++) begin
            i_in_valid = 1'b1;
            i_in_data  = CW'(w);
            i_ag_done  = (w == 50);
            #1;
            if (o_in_ready !== 1'b1 || o_ram_we !== 1'b1 || o_ram_sel !== 1'b0 ||
                o_ram_addr !== 8'(w) || o_ram_wdata !== CW'(w) || o_job_ready !== 1'b0) bad++;
            tick();
        end
        i_in_valid = 1'b0;
        i_ag_done  = 1'b0;
        #1;
        check("load1_writes", bad, 0);
        check("load1_wr_count", wr_count, 256);
        check("run_entry_sel", {31'd0, o_ram_sel}, 32'd1);
        check("run_entry_start", {31'd0, o_ag_start}, 32'd1);
        check("run_entry_in_ready", {31'd0, o_in_ready}, 32'd0);

        run_and_drain(900);
`ifdef NTT_SCHED_PERF_EN
        check("run_cycles", 32'(o_run_cycles), 32'd904);
`endif

        // Unload with addr^A5 read data, toggling ready, job request held
        xor_mode    = 1'b1;
        i_job_valid = 1'b1;
        unload_job(1'b1, 1'b1);
        #1;
        check("idle_after_unload", {31'd0, o_busy}, 32'd0);
        check("idle_job_ready", {31'd0, o_job_ready}, 32'd1);
        check("idle_out_valid", {31'd0, o_out_valid}, 32'd0);
        tick();
        i_job_valid = 1'b0;
        xor_mode    = 1'b0;
        #1;
        check("job2_started", {31'd0, o_in_ready}, 32'd1);

        // Job 2: reset in the middle of the load
        bad = 0;
        for (int w = 0; w < 100; w++) begin
            i_in_valid = 1'b1;
            i_in_data  = CW'($urandom_range(0, 4095));
            #1;
            if (o_ram_we !== 1'b1 || o_ram_addr !== 8'(w)) bad++;
            tick();
        end
        check("load2_writes", bad, 0);
        wc  = wr_count;
        rst = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, o_ram_we}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, o_in_ready}, 32'd0);
        check("mid_rst_wdata", 32'(o_ram_wdata), 32'd0);
        check("mid_rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        tick();
        tick();
        tick();
        check("mid_rst_no_write", wr_count, wc);
        check("mid_rst_total", wr_count, 356);
        rst        = 1'b0;
        i_in_valid = 1'b0;

        // Job 3: gapped load with random data, random run length and ready
        tick();
        i_job_valid = 1'b1;
        #1;
        check("job3_ready", {31'd0, o_job_ready}, 32'd1);
        tick();
        i_job_valid = 1'b0;
        bad = 0;
        k   = 0;
        cyc = 0;
        while (k < 256 && cyc < 2000) begin
            d          = CW'($urandom_range(0, 4095));
            i_in_valid = (cyc % 4 == 0);
            i_in_data  = d;
            #1;
            if (i_in_valid) begin
                if (k == 0) check("reload_addr0", 32'(o_ram_addr), 32'd0);
                if (o_ram_we !== 1'b1 || o_ram_addr !== 8'(k) || o_ram_wdata !== d) bad++;
                ref_mem[k] = d;
                k++;
            end else begin
                if (o_ram_we !== 1'b0) bad++;
            end
            tick();
            cyc++;
        end
        i_in_valid = 1'b0;
        #1;
        check("load3_count", k, 256);
        check("load3_writes", bad, 0);
        check("load3_run", {31'd0, o_ag_start}, 32'd1);

        run_and_drain($urandom_range(1, 40));
        unload_job(1'b0, 1'b0);
        #1;
        check("idle_after_job3", {31'd0, o_busy}, 32'd0);
        check("total_writes", wr_count, 612);
        check("we_while_sel", we_sel_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
